// File: rtl/sram_responder.sv
// sram_responder
//
// Stands in for the board's asynchronous SRAM on the far side of the memory
// stage's SRAM pins. Reads and writes are served from an internal word array
// after a configurable number of cycles with the pins held stable. This lets
// stall and wait-state behaviour run on-chip and in simulation.
//
// Parameters
//   DEPTH      words of storage (power of 2). The low log2(DEPTH) address
//              bits select the word and upper address bits alias.
//   READ_LAT   stable cycles before read data is driven (1..7)
//   WRITE_LAT  stable cycles before a write commits (1..7)
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   sram_addr     18-bit word address
//   sram_data     16-bit bidirectional data bus. It is driven only while
//                 read data is valid and the live pins request a read.
//   sram_ce_n     chip enable (active-low)
//   sram_oe_n     output enable (active-low)
//   sram_we_n     write enable (active-low). It takes priority over oe_n.
//   sram_ub_n     upper byte lane [15:8] enable (active-low)
//   sram_lb_n     lower byte lane [7:0] enable (active-low)
//   busy          FSM is not IDLE
//   rd_valid      registered. Read data is valid and may be driven.
//   write_count   committed writes, wraps modulo 2^16
//   dbg_state     current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 WHOLD)
//   dbg_bus_oe    byte-lane drive enables: [1] upper lane, [0] lower lane
//
// Handshake: a request is sampled on every rising edge and is never
// acknowledged explicitly. The initiator holds CE/OE/WE and the address
// stable until rd_valid rises, for a read, or for WRITE_LAT edges, for a
// write. Any change to the request before then abandons it. After an
// abandoned request, or after a held write is released, the responder
// ignores the request at the next edge (one bubble cycle).

module sram_responder #(
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    input  logic        sram_ce_n,
    input  logic        sram_oe_n,
    input  logic        sram_we_n,
    input  logic        sram_ub_n,
    input  logic        sram_lb_n,
    output logic        busy,
    output logic        rd_valid,
    output logic [15:0] write_count,
    output logic [1:0]  dbg_state,
    output logic [1:0]  dbg_bus_oe
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [2:0] RD_LAT = 3'(READ_LAT);
    localparam logic [2:0] WR_LAT = 3'(WRITE_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_WHOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            rd_valid_q, rd_valid_d;
    logic [15:0]     wcount_q, wcount_d;

    logic [15:0]     mem [DEPTH];

    logic [AW-1:0]   req_idx;
    logic            req_wr;
    logic            req_rd;
    logic            same_addr;
    logic            commit;
    logic            rd_load;
    logic [2:0]      cnt_inc;
    logic            oe_hi;
    logic            oe_lo;

    // Upper address bits are intentionally ignored (aliasing).
    generate
        if (AW < 18) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^sram_addr[17:AW];
        end
    endgenerate

    assign req_idx   = sram_addr[AW-1:0];
    // A write takes priority: we_n low with oe_n low is a write, never a read.
    assign req_wr    = !sram_ce_n && !sram_we_n;
    assign req_rd    = !sram_ce_n && sram_we_n && !sram_oe_n;
    assign same_addr = (req_idx == addr_q);
    assign cnt_inc   = cnt_q + 3'd1;

    // Next-state logic. Every non-IDLE state returns to IDLE on any change
    // of the request. This gives the one-cycle bubble before a new request.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        commit     = 1'b0;
        rd_load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_wr) begin
                    addr_d = req_idx;
                    cnt_d  = 3'd1;
                    if (WR_LAT == 3'd1) begin
                        commit  = 1'b1;
                        state_d = S_WHOLD;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else if (req_rd) begin
                    addr_d  = req_idx;
                    cnt_d   = 3'd1;
                    state_d = S_READ;
                    if (RD_LAT == 3'd1) begin
                        rd_load = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (req_rd && same_addr) begin
                    // cnt saturates at the latency value and holds there.
                    if (cnt_q < RD_LAT) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == RD_LAT) begin
                            rd_load = 1'b1;
                        end
                    end
                end else begin
                    state_d    = S_IDLE;
                    rd_valid_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (req_wr && same_addr) begin
                    if (cnt_q < WR_LAT) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == WR_LAT) begin
                            commit  = 1'b1;
                            state_d = S_WHOLD;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WHOLD: begin
                // A held write has already committed and is not repeated.
                if (!(req_wr && same_addr)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rd_load) begin
            rd_valid_d = 1'b1;
        end
    end

    // On a read load, req_idx equals the word being read. In IDLE it is the
    // newly latched word; in READ it matches addr_q.
    always_comb begin
        rdata_d  = rd_load ? mem[req_idx] : rdata_q;
        wcount_d = wcount_q + {15'd0, commit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= 3'd0;
            rdata_q    <= 16'h0000;
            rd_valid_q <= 1'b0;
            wcount_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            wcount_q   <= wcount_d;
        end
    end

    // Storage is not reset. It powers up undefined, like the real part. A
    // commit uses the bus data and lane enables sampled at the commit edge.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            if (!sram_ub_n) begin
                mem[req_idx][15:8] <= sram_data[15:8];
            end
            if (!sram_lb_n) begin
                mem[req_idx][7:0] <= sram_data[7:0];
            end
        end
    end

    // The bus drive follows the live pins. Raising we_n, oe_n or ce_n
    // therefore releases the bus in the same cycle, without waiting for
    // the next edge.
    assign oe_hi = rd_valid_q && !sram_ce_n && !sram_oe_n && sram_we_n && !sram_ub_n;
    assign oe_lo = rd_valid_q && !sram_ce_n && !sram_oe_n && sram_we_n && !sram_lb_n;

    assign sram_data[15:8] = oe_hi ? rdata_q[15:8] : 8'hzz;
    assign sram_data[7:0]  = oe_lo ? rdata_q[7:0]  : 8'hzz;

    assign busy        = (state_q != S_IDLE);
    assign rd_valid    = rd_valid_q;
    assign write_count = wcount_q;
    assign dbg_state   = state_q;
    assign dbg_bus_oe  = {oe_hi, oe_lo};

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder (DEPTH=1024, READ_LAT=2, WRITE_LAT=2).
// Inputs change just after the falling edge. A behavioural model updates on
// the rising edge, and a compare process checks the DUT 3 ns after each
// rising edge. Directed literal checks pin down the model's expectations.

module tb_sram_responder;

    localparam int DEPTH     = 1024;
    localparam int READ_LAT  = 2;
    localparam int WRITE_LAT = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [17:0] sram_addr = '0;
    logic        sram_ce_n = 1'b1;
    logic        sram_oe_n = 1'b1;
    logic        sram_we_n = 1'b1;
    logic        sram_ub_n = 1'b0;
    logic        sram_lb_n = 1'b0;
    logic [15:0] tb_data   = '0;
    logic        tb_drive  = 1'b0;
    wire  [15:0] sram_data;
    logic        busy;
    logic        rd_valid;
    logic [15:0] write_count;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_bus_oe;

    assign sram_data = tb_drive ? tb_data : 16'hzzzz;

    sram_responder #(
        .DEPTH(DEPTH),
        .READ_LAT(READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sram_addr(sram_addr),
        .sram_data(sram_data),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n),
        .busy(busy),
        .rd_valid(rd_valid),
        .write_count(write_count),
        .dbg_state(dbg_state),
        .dbg_bus_oe(dbg_bus_oe)
    );

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks the current request as a run: its kind, its word,
    // and how many consecutive edges it has been seen. A write lands once
    // its run reaches WRITE_LAT. Read data appears once the run reaches
    // READ_LAT. A broken run costs one ignored edge.
    logic [15:0] model_mem [DEPTH];
    int          m_kind = 0;       // 0 none, 1 read, 2 write
    int          m_idx = 0;
    int          m_len = 0;
    logic        m_active = 1'b0;
    logic        m_rd_valid = 1'b0;
    logic [15:0] m_rdata = '0;
    logic [15:0] m_count = '0;
    int          s_kind;
    int          s_idx;

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active   = 1'b0;
            m_len      = 0;
            m_rd_valid = 1'b0;
            m_rdata    = '0;
            m_count    = '0;
        end else begin
            s_kind = (!sram_ce_n && !sram_we_n) ? 2 : ((!sram_ce_n && !sram_oe_n) ? 1 : 0);
            s_idx  = int'(sram_addr) % DEPTH;
            if (m_active && s_kind == m_kind && s_idx == m_idx) begin
                if (m_len < 100) m_len++;
            end else if (m_active) begin
                m_active   = 1'b0;
                m_rd_valid = 1'b0;
            end else if (s_kind != 0) begin
                m_active = 1'b1;
                m_kind   = s_kind;
                m_idx    = s_idx;
                m_len    = 1;
            end
            if (m_active && m_kind == 2 && m_len == WRITE_LAT) begin
                if (!sram_ub_n) model_mem[m_idx][15:8] = sram_data[15:8];
                if (!sram_lb_n) model_mem[m_idx][7:0]  = sram_data[7:0];
                m_count = m_count + 16'd1;
            end
            if (m_active && m_kind == 1 && m_len == READ_LAT) begin
                m_rdata    = model_mem[m_idx];
                m_rd_valid = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        #3;
        if (started) begin
            logic exp_hi, exp_lo;
            exp_hi = m_rd_valid && !sram_ce_n && !sram_oe_n && sram_we_n && !sram_ub_n;
            exp_lo = m_rd_valid && !sram_ce_n && !sram_oe_n && sram_we_n && !sram_lb_n;
            check("busy", 32'(busy), 32'(m_active));
            check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            check("write_count", 32'(write_count), 32'(m_count));
            check("bus_oe", 32'(dbg_bus_oe), 32'({exp_hi, exp_lo}));
            if (exp_hi) check("bus_hi", 32'(sram_data[15:8]), 32'(m_rdata[15:8]));
            if (exp_lo) check("bus_lo", 32'(sram_data[7:0]), 32'(m_rdata[7:0]));
        end
    end

    // ---------------- driver tasks (called just after a falling edge) ----------------
    task automatic set_idle();
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        tb_drive  = 1'b0;
    endtask

    task automatic set_wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        sram_addr = a;
        tb_data   = d;
        tb_drive  = 1'b1;
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_oe_n = 1'b1;
        sram_ub_n = ub;
        sram_lb_n = lb;
    endtask

    task automatic set_rd(input logic [17:0] a, input logic ub, input logic lb);
        tb_drive  = 1'b0;
        sram_addr = a;
        sram_ce_n = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b0;
        sram_ub_n = ub;
        sram_lb_n = lb;
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Short mixed sequence. It covers aborted and completed reads and
    // writes, aliasing, and a read issued back to back after a write.
    typedef struct {
        logic        is_wr;
        logic [17:0] addr;
        logic [15:0] data;
        int          hold;
        int          gap;
    } op_t;

    op_t ops [7];

    initial begin
        ops[0] = '{1'b1, 18'h003FF, 16'h0F0F, 1, 1};  // aborted write
        ops[1] = '{1'b1, 18'h003FF, 16'hA5A5, 2, 1};  // exact-latency write
        ops[2] = '{1'b0, 18'h003FF, 16'h0000, 1, 1};  // aborted read
        ops[3] = '{1'b0, 18'h003FF, 16'h0000, 3, 1};  // held read
        ops[4] = '{1'b1, 18'h203FF, 16'h5A5A, 3, 0};  // aliased write, no gap
        ops[5] = '{1'b0, 18'h003FF, 16'h0000, 3, 1};  // bubble then read
        ops[6] = '{1'b0, 18'h00005, 16'h0000, 2, 1};
    end

    // ---------------- directed sequence ----------------
    initial begin
        set_idle();
        edges(3);
        started = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_write_count", 32'(write_count), 32'd0);
        check("reset_bus_oe", 32'(dbg_bus_oe), 32'd0);
        rst = 1'b0;
        edges(1);

        // Write then read
        set_wr(18'h00005, 16'hBEEF, 1'b0, 1'b0);
        edges(4);
        set_idle();
        edges(1);
        check("wr_count_1", 32'(write_count), 32'd1);
        set_rd(18'h00005, 1'b0, 1'b0);
        @(posedge clk); #4;
        check("rd_lat_not_yet", 32'(rd_valid), 32'd0);
        @(posedge clk); #4;
        check("rd_lat_valid", 32'(rd_valid), 32'd1);
        check("rd_beef", 32'(sram_data), 32'h0000BEEF);
        @(negedge clk);
        set_idle();
        edges(1);

        // Byte lanes
        set_wr(18'h00003, 16'h1234, 1'b0, 1'b0);
        edges(2);
        set_idle();
        edges(1);
        set_wr(18'h00003, 16'hABCD, 1'b1, 1'b0);
        edges(2);
        set_idle();
        edges(1);
        check("lane_count", 32'(write_count), 32'd3);
        set_rd(18'h00003, 1'b0, 1'b1);
        edges(2);
        check("lane_oe_upper_only", 32'(dbg_bus_oe), 32'h2);
        check("lane_upper_byte", 32'(sram_data[15:8]), 32'h12);
        sram_lb_n = 1'b0;
        #1;
        check("lane_merged_word", 32'(sram_data), 32'h000012CD);
        edges(1);
        set_idle();
        edges(1);

        // Abort
        set_wr(18'h00007, 16'h7777, 1'b0, 1'b0);
        edges(2);
        set_idle();
        edges(1);
        set_wr(18'h00007, 16'h5555, 1'b0, 1'b0);
        edges(1);
        set_idle();
        edges(2);
        check("abort_count", 32'(write_count), 32'd4);
        check("abort_idle", 32'(busy), 32'd0);
        set_rd(18'h00007, 1'b0, 1'b0);
        edges(2);
        check("abort_mem_kept", 32'(sram_data), 32'h00007777);
        set_idle();
        edges(1);

        // Aliasing and contention
        set_wr(18'h00400, 16'h0001, 1'b0, 1'b0);
        edges(2);
        set_idle();
        edges(1);
        set_rd(18'h00000, 1'b0, 1'b0);
        edges(2);
        check("alias_read", 32'(sram_data), 32'h00000001);
        sram_we_n = 1'b0;
        #1;
        check("contention_release", 32'(dbg_bus_oe), 32'd0);
        check("contention_rd_valid_reg", 32'(rd_valid), 32'd1);
        #1;
        set_idle();
        edges(2);

        // Write dominance and hold
        set_wr(18'h00002, 16'hCAFE, 1'b0, 1'b0);
        sram_oe_n = 1'b0;
        edges(6);
        set_idle();
        edges(1);
        check("hold_single_commit", 32'(write_count), 32'd6);
        set_rd(18'h00002, 1'b0, 1'b0);
        edges(2);
        check("hold_read", 32'(sram_data), 32'h0000CAFE);
        set_idle();
        edges(1);

        // Mixed table, checked by the model
        foreach (ops[i]) begin
            if (ops[i].is_wr) set_wr(ops[i].addr, ops[i].data, 1'b0, 1'b0);
            else set_rd(ops[i].addr, 1'b0, 1'b0);
            edges(ops[i].hold);
            if (ops[i].gap > 0) begin
                set_idle();
                edges(ops[i].gap);
            end
        end
        check("table_count", 32'(write_count), 32'd8);

        // Reset mid-write loses the write
        set_wr(18'h00009, 16'h1111, 1'b0, 1'b0);
        edges(2);
        set_idle();
        edges(1);
        set_wr(18'h00009, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #4;
        check("rst_wr_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_wr_busy", 32'(busy), 32'd0);
        check("rst_wr_count", 32'(write_count), 32'd0);
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        edges(1);
        set_rd(18'h00009, 1'b0, 1'b0);
        edges(2);
        check("rst_wr_lost", 32'(sram_data), 32'h00001111);
        set_idle();
        edges(1);

        // Reset mid-read
        set_rd(18'h00010, 1'b0, 1'b0);
        @(posedge clk); #4;
        check("rst_rd_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_rd_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_bus_released", 32'(dbg_bus_oe), 32'd0);
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        edges(2);

        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the external asynchronous-SRAM pin interface that the pipeline's memory stage drives. It sits on the far side of the SRAM pins: CE/OE/WE/UB/LB, an 18-bit address and a 16-bit bidirectional data bus. It serves reads and writes from an internal word array with configurable access latency, so memory-stage stall and wait-state behaviour can run on-chip and in simulation without the board SRAM. It also reports busy, read-valid and a write-commit count for debug.

## Interface
- DEPTH, 1024: words of storage; power of 2; word index = low log2(DEPTH) address bits, upper address bits ignored (aliasing).
- READ_LAT, 2: sampled-stable cycles before read data drives the bus; legal 1..7.
- WRITE_LAT, 2: sampled-stable cycles before a write commits; legal 1..7.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sram_addr  in  18  word address.
- sram_data  inout  16  data bus; driven only as specified below, otherwise high-Z.
- sram_ce_n  in  1  chip enable, active-low.
- sram_oe_n  in  1  output enable, active-low.
- sram_we_n  in  1  write enable, active-low; dominates oe_n.
- sram_ub_n  in  1  upper byte lane [15:8] enable, active-low.
- sram_lb_n  in  1  lower byte lane [7:0] enable, active-low.
- busy  out  1  high when state is not IDLE.
- rd_valid  out  1  registered; read data is valid and being driven.
- write_count  out  16  number of committed writes, wraps modulo 2^16.

## Operation
- Request decode at each edge: WR = !ce_n & !we_n; RD = !ce_n & we_n & !oe_n; otherwise none. If we_n and oe_n are both low, the request is a write.
- States: IDLE, READ, WRITE, WHOLD. The FSM latches addr_q (the word index) and a 3-bit counter cnt.
- IDLE: on WR, latch addr_q and set cnt=1. If WRITE_LAT==1, commit at this edge and go to WHOLD; else go to WRITE. On RD, latch addr_q and set cnt=1. If READ_LAT==1, load rdata_q and set rd_valid=1; go to READ either way.
- READ: if the request is still RD and addr matches addr_q, increment cnt while cnt<READ_LAT. When the edge makes cnt reach READ_LAT, load rdata_q=mem[addr_q] and set rd_valid=1. rd_valid holds while the request stays stable. Any other condition (address change, ce_n/oe_n high, we_n low) aborts: go to IDLE and clear rd_valid.
- WRITE: while WR is stable at the same address, increment cnt. At the edge where cnt reaches WRITE_LAT, commit and go to WHOLD. On abort, go to IDLE with no memory change.
- Commit: mem[addr_q][15:8] gets sram_data[15:8] if !ub_n. mem[addr_q][7:0] gets sram_data[7:0] if !lb_n. Data and lane enables are sampled at the commit edge. write_count increments even when both lanes are disabled.
- WHOLD: stay while WR remains asserted at the same address, with no further commits. Any change returns to IDLE. A held write therefore commits exactly once.
- After an abort or a WHOLD exit, IDLE samples the next request one edge later (one bubble cycle).
- Bus drive is combinational on the live pins. Upper byte = rdata_q[15:8] when rd_valid & !ce_n & !oe_n & we_n & !ub_n, else Z. Lower byte uses the same rule with lb_n. The bus is never driven while we_n is low.
- Memory contents are not cleared by rst. They are X after power-up in simulation.

## Timing
- Reset values: state IDLE, busy=0, rd_valid=0, write_count=0, cnt=0, rdata_q=0, bus high-Z. rst asserted mid-access aborts it with no commit; an in-flight write is lost.
- Read latency: with a request first sampled at edge k, rd_valid rises after edge k+READ_LAT-1.
- Write commit occurs at edge k+WRITE_LAT-1. The pins must remain stable from k through the commit edge.
- A read of an address written by the immediately preceding write returns the new data.
- cnt saturates at the latency value and never wraps.

## Test plan
- Reset mid-read: READ_LAT=2, RD at 0x0010, rst pulse after one edge -> busy=0, rd_valid=0, bus Z immediately; no data driven.
- Write then read: WR addr 0x0005 data 0xBEEF held 4 cycles, then RD 0x0005 -> write_count=1; rd_valid high 2 edges after RD sampled; bus=0xBEEF.
- Byte lanes: mem[3]=0x1234; write 0xABCD with ub_n=1, lb_n=0 -> mem[3]=0x12CD. Read with ub_n=0, lb_n=1 -> bus[15:8]=0x12, bus[7:0]=Z.
- Abort: WR 0x0007 data 0x5555 for 1 cycle (WRITE_LAT=2), then ce_n=1 -> no commit, write_count unchanged, mem[7] unchanged.
- Aliasing and contention: WR 0x00400 (DEPTH=1024) data 0x0001, then RD 0x00000 -> 0x0001. Asserting we_n=0 during a valid read releases the bus in the same cycle.
- Write dominance and hold: we_n=0 and oe_n=0 together for 6 cycles at 0x0002 -> exactly one commit; bus never driven.
